// File: rtl/gesture_pkg.sv
// Shared types and default parameter values for the gesture power controller.
`timescale 1ns/1ps
package gesture_pkg;

  // FSM encoding: idle, waiting for right key (power-on), waiting for left key (power-off)
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ON_ARMED  = 2'd1,
    ST_OFF_ARMED = 2'd2
  } gesture_state_t;

  localparam int unsigned DEF_CLK_HZ            = 100_000_000;
  localparam int unsigned DEF_SEC_W             = 4;
  localparam int unsigned DEF_DEFAULT_SEC       = 5;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 300_000_000;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/gesture_power_ctrl_param_long_press_detect.sv
// Long-press detector: counts consecutive high cycles of a key and emits a
// single-cycle toggle on the LONG_PRESS_CYCLES-th one, then locks until release.
`timescale 1ns/1ps
module long_press_detect
  import gesture_pkg::*;
#(
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_toggle
);

  localparam int unsigned   CW       = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [CW-1:0] HOLD_MAX = CW'(LONG_PRESS_CYCLES - 32'd1);

  logic [CW-1:0] r_hold_cnt;
  logic          r_lock;
  logic          w_hit;

  // The counter value equals (high cycles so far - 1), so a match fires during
  // the LONG_PRESS_CYCLES-th high cycle and the caller acts on the next edge.
  assign w_hit    = i_key && !r_lock && (r_hold_cnt == HOLD_MAX);
  assign o_toggle = w_hit;

  // Hold counter and lock: clear on release, saturate and lock after a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= {CW{1'b0}};
      r_lock     <= 1'b0;
    end else if (!i_key) begin
      r_hold_cnt <= {CW{1'b0}};
      r_lock     <= 1'b0;
    end else if (w_hit) begin
      r_lock     <= 1'b1;
    end else if (r_hold_cnt != HOLD_MAX) begin
      r_hold_cnt <= r_hold_cnt + CW'(1'b1);
    end else begin
      r_hold_cnt <= r_hold_cnt;
    end
  end

endmodule

// File: rtl/gesture_power_ctrl_param.sv
// Gesture power controller: left->right powers on, right->left powers off,
// each within a window of S seconds; a long press of power_key toggles power.
`timescale 1ns/1ps
module gesture_power_ctrl_param
  import gesture_pkg::*;
#(
  parameter int unsigned CLK_HZ            = DEF_CLK_HZ,
  parameter int unsigned SEC_W             = DEF_SEC_W,
  parameter int unsigned DEFAULT_SEC       = DEF_DEFAULT_SEC,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_key,
  input  logic             right_key,
  input  logic             power_key,
  input  logic [SEC_W-1:0] timeout_sec,
  output logic             power_state,
  output logic             gesture_busy,
  output logic [SEC_W-1:0] countdown_sec,
  output logic             gesture_done,
  output logic             timeout_pulse
);

  localparam int unsigned      PW        = cnt_width(CLK_HZ);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_HZ - 32'd1);
  localparam logic [PW-1:0]    PRESC_0   = {PW{1'b0}};
  localparam logic [SEC_W-1:0] SEC_DEF   = SEC_W'(DEFAULT_SEC);
  localparam logic [SEC_W-1:0] SEC_0     = {SEC_W{1'b0}};
  localparam logic [SEC_W-1:0] SEC_1     = SEC_W'(1'b1);

  gesture_state_t   r_state;
  gesture_state_t   w_state_nxt;
  logic             r_left_prev;
  logic             r_right_prev;
  logic [PW-1:0]    r_presc;
  logic [SEC_W-1:0] r_sec;
  logic             r_power;
  logic             r_busy;
  logic             r_done;
  logic             r_tmo;

  logic             w_left_rise;
  logic             w_right_rise;
  logic             w_toggle;
  logic [SEC_W-1:0] w_window;
  logic             w_armed;
  logic             w_arm_on;
  logic             w_arm_off;
  logic             w_complete;
  logic             w_restart;
  logic             w_expire;
  logic [PW-1:0]    w_presc_nxt;
  logic [SEC_W-1:0] w_sec_nxt;
  logic             w_power_nxt;
  logic             w_done_nxt;
  logic             w_tmo_nxt;

  long_press_detect #(
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_long_press (
    .clk     (clk),
    .rst_n   (reset),
    .i_key   (power_key),
    .o_toggle(w_toggle)
  );

  // Previous-value registers reset high so a key held through reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_left_prev  <= 1'b1;
      r_right_prev <= 1'b1;
    end else begin
      r_left_prev  <= left_key;
      r_right_prev <= right_key;
    end
  end

  assign w_left_rise  = left_key  && !r_left_prev;
  assign w_right_rise = right_key && !r_right_prev;
  assign w_window     = (timeout_sec == SEC_0) ? SEC_DEF : timeout_sec;

  // Event decode shared by the next-state and output processes.
  assign w_armed    = (r_state == ST_ON_ARMED) || (r_state == ST_OFF_ARMED);
  assign w_arm_on   = (r_state == ST_IDLE) && w_left_rise && !w_right_rise && !r_power && !w_toggle;
  assign w_arm_off  = (r_state == ST_IDLE) && w_right_rise && !w_left_rise && r_power && !w_toggle;
  assign w_complete = ((r_state == ST_ON_ARMED) && w_right_rise) ||
                      ((r_state == ST_OFF_ARMED) && w_left_rise);
  assign w_restart  = ((r_state == ST_ON_ARMED) && w_left_rise) ||
                      ((r_state == ST_OFF_ARMED) && w_right_rise);
  // Window closes at the prescaler wrap that would take the seconds counter below 1.
  assign w_expire   = w_armed && (r_presc == PRESC_MAX) && (r_sec <= SEC_1);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; priority in armed states is toggle > completion > restart > timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_arm_on) begin
          w_state_nxt = ST_ON_ARMED;
        end else if (w_arm_off) begin
          w_state_nxt = ST_OFF_ARMED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ON_ARMED, ST_OFF_ARMED: begin
        if (w_toggle || w_complete) begin
          w_state_nxt = ST_IDLE;
        end else if (w_restart) begin
          w_state_nxt = r_state;
        end else if (w_expire) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: next power, pulses, prescaler and seconds counter values.
  always_comb begin
    w_power_nxt = r_power;
    w_done_nxt  = 1'b0;
    w_tmo_nxt   = 1'b0;
    w_presc_nxt = PRESC_0;
    w_sec_nxt   = SEC_0;
    case (r_state)
      ST_IDLE: begin
        if (w_toggle) begin
          w_power_nxt = !r_power;
        end else if (w_arm_on || w_arm_off) begin
          w_sec_nxt   = w_window;
        end else begin
          w_sec_nxt   = SEC_0;
        end
      end
      ST_ON_ARMED, ST_OFF_ARMED: begin
        if (w_toggle) begin
          w_power_nxt = !r_power;
        end else if (w_complete) begin
          w_power_nxt = (r_state == ST_ON_ARMED);
          w_done_nxt  = 1'b1;
        end else if (w_restart) begin
          w_sec_nxt   = w_window;
        end else if (w_expire) begin
          w_tmo_nxt   = 1'b1;
        end else if (r_presc == PRESC_MAX) begin
          w_sec_nxt   = r_sec - SEC_1;
        end else begin
          w_sec_nxt   = r_sec;
          w_presc_nxt = r_presc + PW'(1'b1);
        end
      end
      default: begin
        w_power_nxt = r_power;
      end
    endcase
  end

  // Output and counter registers; all externally visible values come from here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_power <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
      r_presc <= PRESC_0;
      r_sec   <= SEC_0;
    end else begin
      r_power <= w_power_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_done_nxt;
      r_tmo   <= w_tmo_nxt;
      r_presc <= w_presc_nxt;
      r_sec   <= w_sec_nxt;
    end
  end

  assign power_state   = r_power;
  assign gesture_busy  = r_busy;
  assign countdown_sec = r_sec;
  assign gesture_done  = r_done;
  assign timeout_pulse = r_tmo;

endmodule

// File: tb/tb_gesture_power_ctrl_param.sv
// Scoreboard bench for gesture_power_ctrl_param with CLK_HZ=10, DEFAULT_SEC=2,
// LONG_PRESS_CYCLES=8. Expected outputs for each sampled cycle are queued as
// stimulus is applied and compared once the DUT has clocked.
`timescale 1ns/1ps
module tb_gesture_power_ctrl_param;

  logic       clk;
  logic       reset;
  logic       left_key;
  logic       right_key;
  logic       power_key;
  logic [3:0] timeout_sec;
  logic       power_state;
  logic       gesture_busy;
  logic [3:0] countdown_sec;
  logic       gesture_done;
  logic       timeout_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic       pwr;
    logic       busy;
    logic       done;
    logic       tmo;
    logic [3:0] cd;
  } exp_t;

  exp_t sb[$];

  gesture_power_ctrl_param #(
    .CLK_HZ           (10),
    .SEC_W            (4),
    .DEFAULT_SEC      (2),
    .LONG_PRESS_CYCLES(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .left_key     (left_key),
    .right_key    (right_key),
    .power_key    (power_key),
    .timeout_sec  (timeout_sec),
    .power_state  (power_state),
    .gesture_busy (gesture_busy),
    .countdown_sec(countdown_sec),
    .gesture_done (gesture_done),
    .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input string tag, input logic p, input logic b,
                          input logic d, input logic t, input int cd);
    exp_t e;
    e.tag  = tag;
    e.pwr  = p;
    e.busy = b;
    e.done = d;
    e.tmo  = t;
    e.cd   = 4'(cd);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, "/power"},   {31'd0, power_state},   {31'd0, e.pwr});
    chk({e.tag, "/busy"},    {31'd0, gesture_busy},  {31'd0, e.busy});
    chk({e.tag, "/done"},    {31'd0, gesture_done},  {31'd0, e.done});
    chk({e.tag, "/timeout"}, {31'd0, timeout_pulse}, {31'd0, e.tmo});
    chk({e.tag, "/count"},   {28'd0, countdown_sec}, {28'd0, e.cd});
  endtask

  // Queue the expectation for the cycle after the next edge, clock, then compare.
  task automatic step(input string tag, input logic p, input logic b,
                      input logic d, input logic t, input int cd);
    push_exp(tag, p, b, d, t, cd);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Immediate comparison without waiting for a clock edge.
  task automatic now_chk(input string tag, input logic p, input logic b,
                         input logic d, input logic t, input int cd);
    push_exp(tag, p, b, d, t, cd);
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    left_key    = 1'b0;
    right_key   = 1'b0;
    power_key   = 1'b0;
    timeout_sec = 4'd0;
    #12;
    now_chk("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Both rises together in IDLE: no effect.
    left_key = 1'b1; right_key = 1'b1;
    step("both_rise", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    left_key = 1'b0; right_key = 1'b0;
    step("both_after", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Timeout of a power-on window: 20 busy cycles, pulse on the 21st.
    left_key = 1'b1;
    step("tmo_arm", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    left_key = 1'b0;
    for (int k = 1; k < 20; k++) step("tmo_win", 1'b0, 1'b1, 1'b0, 1'b0, (k < 10) ? 2 : 1);
    step("tmo_pulse", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    step("tmo_after", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Repeated left rise restarts the window and countdown returns to 2.
    left_key = 1'b1;
    step("rst_arm", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    left_key = 1'b0;
    for (int k = 1; k < 12; k++) step("rst_win", 1'b0, 1'b1, 1'b0, 1'b0, (k < 10) ? 2 : 1);
    left_key = 1'b1;
    step("restart", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    left_key = 1'b0;
    for (int k = 1; k < 20; k++) step("restart_win", 1'b0, 1'b1, 1'b0, 1'b0, (k < 10) ? 2 : 1);
    step("restart_tmo", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    step("restart_after", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Power-on gesture: right rise 5 cycles after left rise.
    left_key = 1'b1;
    step("on_arm", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    left_key = 1'b0;
    for (int k = 1; k < 5; k++) step("on_win", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    right_key = 1'b1;
    step("on_done", 1'b1, 1'b0, 1'b1, 1'b0, 0);
    right_key = 1'b0;
    step("on_after", 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Power-off with a 1 s window, completed in its last (10th) cycle.
    timeout_sec = 4'd1;
    right_key = 1'b1;
    step("off_arm", 1'b1, 1'b1, 1'b0, 1'b0, 1);
    right_key = 1'b0;
    for (int k = 1; k < 10; k++) step("off_win", 1'b1, 1'b1, 1'b0, 1'b0, 1);
    left_key = 1'b1;
    step("off_last", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    left_key = 1'b0;
    step("off_after", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Power back on with the 1 s window.
    left_key = 1'b1;
    step("on2_arm", 1'b0, 1'b1, 1'b0, 1'b0, 1);
    left_key = 1'b0;
    right_key = 1'b1;
    step("on2_done", 1'b1, 1'b0, 1'b1, 1'b0, 0);
    right_key = 1'b0;
    step("on2_after", 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Power-off attempt one cycle too late: timeout, power stays on.
    right_key = 1'b1;
    step("late_arm", 1'b1, 1'b1, 1'b0, 1'b0, 1);
    right_key = 1'b0;
    for (int k = 1; k < 10; k++) step("late_win", 1'b1, 1'b1, 1'b0, 1'b0, 1);
    step("late_tmo", 1'b1, 1'b0, 1'b0, 1'b1, 0);
    left_key = 1'b1;
    step("late_left", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    left_key = 1'b0;
    step("late_after", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    timeout_sec = 4'd0;

    // Long press in IDLE: one toggle on the 8th edge of a 30-cycle hold.
    power_key = 1'b1;
    for (int k = 1; k <= 30; k++) step("lp_idle", (k < 8) ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 0);
    power_key = 1'b0;
    step("lp_release", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Long press during ON_ARMED: toggle, back to IDLE, no pulses afterwards.
    left_key = 1'b1;
    step("lpa_arm", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    left_key = 1'b0;
    power_key = 1'b1;
    for (int k = 1; k < 8; k++) step("lpa_win", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    step("lpa_toggle", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) step("lpa_hold", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    power_key = 1'b0;
    for (int k = 0; k < 25; k++) step("lpa_quiet", 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Asynchronous reset in OFF_ARMED, with left key held through release.
    right_key = 1'b1;
    step("mid_arm", 1'b1, 1'b1, 1'b0, 1'b0, 2);
    right_key = 1'b0;
    step("mid_win", 1'b1, 1'b1, 1'b0, 1'b0, 2);
    #3;
    reset = 1'b0;
    #1;
    now_chk("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    left_key = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) step("held_left", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    left_key = 1'b0;
    step("held_drop", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    left_key = 1'b1;
    step("post_arm", 1'b0, 1'b1, 1'b0, 1'b0, 2);
    left_key = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gesture_power_ctrl_param.md
# gesture_power_ctrl_param

Parametrised gesture power controller. Power-on is a left→right key gesture and power-off is a right→left key gesture, each completed within a runtime-selectable window measured in seconds. A long press of a dedicated power key toggles power and overrides any gesture in progress. The block sits between the debounced key inputs and the system power-enable net, and exports countdown and status signals for the display logic.

## Interface
- `CLK_HZ`, 100_000_000: clock cycles per second; also the seconds prescaler period.
- `SEC_W`, 4: width of the seconds fields.
- `DEFAULT_SEC`, 5: window length used when `timeout_sec` is 0.
- `LONG_PRESS_CYCLES`, 300_000_000: hold time before `power_key` toggles power; must be ≥ 2.
- `clk`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `left_key`  in  1  debounced level, synchronous to `clk`.
- `right_key`  in  1  debounced level, synchronous to `clk`.
- `power_key`  in  1  debounced level; long-press toggle.
- `timeout_sec`  in  SEC_W  window length in seconds; 0 selects DEFAULT_SEC; sampled only at arm.
- `power_state`  out  1  registered power enable.
- `gesture_busy`  out  1  high while in ON_ARMED or OFF_ARMED.
- `countdown_sec`  out  SEC_W  remaining whole seconds of the open window; 0 in IDLE.
- `gesture_done`  out  1  one-cycle pulse on gesture completion.
- `timeout_pulse`  out  1  one-cycle pulse when a window expires without completion.

## Operation
- Rising edge of a key = key high and its registered previous value low. Previous-value registers reset to 1, so a key held through reset release produces no edge.
- States: IDLE, ON_ARMED, OFF_ARMED.
- IDLE transitions:
  - `left_rise` with power 0 → ON_ARMED.
  - `right_rise` with power 1 → OFF_ARMED.
  - Both rises in the same cycle → stay in IDLE, no effect.
- On arm: seconds counter loads the effective window S; prescaler clears.
- ON_ARMED:
  - `right_rise` → power 1, `gesture_done` pulse, IDLE.
  - Repeated `left_rise` → reload S and prescaler (window restarts).
  - Window exhausted → `timeout_pulse`, IDLE.
- OFF_ARMED: mirror of ON_ARMED with keys swapped; completion sets power 0.
- Priority in an armed state: long-press toggle > completion > restart > timeout.
- Prescaler counts 0..CLK_HZ-1. At wrap, the seconds counter decrements. The window closes when the counter would decrement from 1.
- `countdown_sec` = seconds counter in armed states, otherwise 0.
- Long press:
  - Hold counter increments while `power_key` is high and clears when it is low.
  - Reaching LONG_PRESS_CYCLES-1 toggles power once and locks until `power_key` is released.
  - In an armed state the toggle forces IDLE with no `timeout_pulse` or `gesture_done`.
- Reset (asynchronous, any time) gives:
  - state IDLE;
  - `power_state`, `gesture_busy`, `countdown_sec`, both pulses, all counters and the lock = 0;
  - previous-key registers = 1.

## Timing
- Detection cycle = the cycle in which a rise is seen.
- State, `power_state`, pulses, `gesture_busy` and `countdown_sec` all update on the next clock edge (1-cycle latency); all outputs are registered.
- Window: the armed state lasts exactly S×CLK_HZ cycles after the arm edge.
  - A completion rise in any of those cycles is accepted, including the last.
  - The first IDLE cycle after expiry carries `timeout_pulse`.
- `countdown_sec` shows S for the first CLK_HZ cycles, then steps down to 1 in the final second.
- The long-press toggle takes effect on the edge after the LONG_PRESS_CYCLES-th consecutive high cycle.

## Structure
- Package `gesture_pkg`: state enumeration (IDLE/ON_ARMED/OFF_ARMED, 2 bits) and the default constant values for the parameters.
- Sub-module `long_press_detect`: hold counter, lock and one-cycle toggle output, parametrised by LONG_PRESS_CYCLES.
- Top level holds edge detection, the FSM, the prescaler and seconds counter, and the output registers.

## Test plan
Bench parameters: CLK_HZ=10, DEFAULT_SEC=2, LONG_PRESS_CYCLES=8, `timeout_sec`=0.
- Power-on gesture: reset; left rise; right rise 5 cycles later → `power_state` 1 and `gesture_done` 1-cycle pulse on the next edge; `countdown_sec` was 2 throughout; `gesture_busy` drops.
- Timeout: left rise only → busy for 20 cycles; `countdown_sec` reads 2 for 10 cycles, then 1 for 10 cycles; `timeout_pulse` on cycle 21; `power_state` stays 0.
- Power-off window edge: power on, `timeout_sec`=1, right rise.
  - Left rise at cycle 10 → `power_state` 0.
  - Repeat with left rise at cycle 11 → `timeout_pulse`, power stays 1.
- Long press: `power_key` high for 30 cycles → exactly one toggle, 8 cycles after press. Pressing again during ON_ARMED → toggle, IDLE, no pulses.
- Edge cases:
  - Left and right rise in the same IDLE cycle → no state change.
  - Left key held high across reset release → no arm.
  - Repeated left rise in ON_ARMED → `countdown_sec` returns to 2.
- Reset mid-window: assert reset during OFF_ARMED → all outputs 0 immediately, before the next clock edge.
